// File: rtl/tbird_switch_cond.sv
// tbird_switch_cond: turn-stalk / hazard switch conditioner for the turn-signal sequencer.
// Each raw contact is synchronized and debounced. A small selector FSM then turns the
// debounced levels into registered left/right requests plus a conflict flag.
// Optional feature macro: TBIRD_HAZARD_EN. When it is undefined, the hazard input is
// ignored and its synchronizer and debouncer are not built.

module tbird_sw_chan #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);

   localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [7:0]             cnt;
   logic                   sync_out;

   assign sync_out = sync[SYNC_STAGES-1];

   // synchronizer shift chain, raw contact enters at bit 0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync <= '0;
      else        sync <= {sync[SYNC_STAGES-2:0], raw};
   end

   // stability counter: a level is accepted only after DEBOUNCE_CYCLES differing samples in a row
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level <= 1'b0;
         cnt   <= '0;
      end else if (sync_out == level) begin
         cnt <= '0;
      end else if (cnt >= LAST) begin
         level <= sync_out;
         cnt   <= '0;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// state  | meaning
// IDLE   | no request, left=0 right=0
// LEFT   | left request locked in, right ignored until left releases
// RIGHT  | right request locked in, left ignored until right releases
// HAZARD | hazard request, both outputs on (reachable only with TBIRD_HAZARD_EN)
module tbird_switch_cond #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic left_sw,
   input  logic right_sw,
   input  logic hazard_sw,
   output logic left,
   output logic right,
   output logic conflict
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      LEFT   = 2'b01,
      RIGHT  = 2'b10,
      HAZARD = 2'b11
   } state_t;

   state_t state, state_nxt;
   logic   deb_l, deb_r, deb_h;

   tbird_sw_chan #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_l (
      .clk(clk), .reset(reset), .raw(left_sw), .level(deb_l)
   );

   tbird_sw_chan #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_r (
      .clk(clk), .reset(reset), .raw(right_sw), .level(deb_r)
   );

`ifdef TBIRD_HAZARD_EN
   tbird_sw_chan #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_h (
      .clk(clk), .reset(reset), .raw(hazard_sw), .level(deb_h)
   );
`else
   // hazard contact deliberately left unconnected in this build
   logic hazard_unused;
   assign hazard_unused = hazard_sw;
   assign deb_h         = 1'b0;
`endif

   // state register; the outputs decode straight from its bits
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state: hazard wins everywhere, otherwise first-come lock on left/right
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (deb_h)               state_nxt = HAZARD;
            else if (deb_l && !deb_r) state_nxt = LEFT;
            else if (deb_r && !deb_l) state_nxt = RIGHT;
         end
         LEFT: begin
            if (deb_h)       state_nxt = HAZARD;
            else if (!deb_l) state_nxt = IDLE;
         end
         RIGHT: begin
            if (deb_h)       state_nxt = HAZARD;
            else if (!deb_r) state_nxt = IDLE;
         end
         HAZARD: begin
            if (!deb_h) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // conflict flag: both stalk directions debounced high without hazard
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) conflict <= 1'b0;
      else        conflict <= deb_l & deb_r & ~deb_h;
   end

   assign left  = state[0];
   assign right = state[1];

endmodule
